fetch_prefetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the single-cycle datapath and supplies its instruction word.
- Owns the fetch PC and issues word requests to the instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers returned words with their PCs in a small FIFO and presents them to decode with valid/ready.
- Accepts branch/jump redirects: flushes the queue and discards any in-flight stale response.

---
 rtl/fetch_prefetch_queue.sv | 153 +++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: owns the PC, requests words over req/ack, queues {pc,word}.
// Optional counters: define FETCH_STATS_EN.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
`ifdef FETCH_STATS_EN
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed,
  output logic [31:0] stat_stall,
`endif
  input  logic        instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, req_addr, pc_inc;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_nxt;
  logic          push, pop, issue;

  assign pc_inc      = fetch_pc + 32'd4;
  assign imem_req    = (state != IDLE);
  assign imem_addr   = imem_req ? req_addr : '0;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? data_q[rptr] : '0;
  assign instr_pc    = instr_valid ? pc_q[rptr] : '0;
  assign push        = (state == WAIT) && imem_ack && !redirect;
  assign pop         = instr_valid && instr_ready && !redirect;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CNT_ONE;
    else if (pop && !push)
      count_nxt = count - CNT_ONE;
    if (redirect)
      count_nxt = '0;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!redirect && count < FULL) begin
          state_nxt = WAIT;
          issue     = 1'b1;
        end
      end
      WAIT: begin
        if (redirect)
          state_nxt = imem_ack ? IDLE : DROP;
        else if (imem_ack) begin
          if (count_nxt < FULL)
            issue = 1'b1;
          else
            state_nxt = IDLE;
        end
      end
      DROP: begin
        // A completed request is never left dangling, even under redirect.
        if (imem_ack)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (redirect)
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (push)
        fetch_pc <= pc_inc;
      // Address register stays frozen in DROP while fetch_pc moves on.
      if (issue)
        req_addr <= (state == WAIT) ? pc_inc : fetch_pc;
      if (redirect) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + PTR_ONE;
        if (pop)  rptr <= rptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wptr]   <= req_addr;
      data_q[wptr] <= imem_rdata;
    end
  end

`ifdef FETCH_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic        dropped;
  logic [31:0] flush_inc;

  assign dropped   = imem_ack &&
                     ((state == DROP) || (state == WAIT && redirect));
  assign flush_inc = (redirect ? 32'(count) : 32'd0) +
                     (dropped ? 32'd1 : 32'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
      stat_stall   <= '0;
    end else begin
      stat_fetched <= sat_add(stat_fetched, push ? 32'd1 : 32'd0);
      stat_flushed <= sat_add(stat_flushed, flush_inc);
      stat_stall   <= sat_add(stat_stall, instr_valid ? 32'd0 : 32'd1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: per-cycle vector table
// plus hand-written reset sequences.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed, stat_stall;
`endif

  // Memory model: each word is its address scrambled by a key.
  assign imem_rdata = imem_addr ^ KEY;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
`ifdef FETCH_STATS_EN
    .stat_fetched(stat_fetched),
    .stat_flushed(stat_flushed),
    .stat_stall  (stat_stall),
`endif
    .instr_ready (instr_ready)
  );

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tv[$];
  int   errs   = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [31:0] rp,
                     input logic a, input logic rd,
                     input logic q, input logic [31:0] ad,
                     input logic v, input logic [31:0] p);
    vec_t t;
    t.redir = r; t.rpc = rp; t.ack = a; t.rdy = rd;
    t.req = q; t.addr = ad; t.vld = v; t.pc = p;
    tv.push_back(t);
  endtask

  task automatic chk_out(input string nm, input logic q,
                         input logic [31:0] ad, input logic v,
                         input logic [31:0] p);
    chk({nm, " req"},   32'(imem_req),    32'(q));
    chk({nm, " addr"},  imem_addr,        ad);
    chk({nm, " valid"}, 32'(instr_valid), 32'(v));
    chk({nm, " pc"},    instr_pc,         p);
    chk({nm, " instr"}, instr,            v ? (p ^ KEY) : 32'h0);
  endtask

  initial begin
    // streaming, ack tied high, ready high
    add(0, 0, 1, 1,  0, 32'h0,  0, 32'h0);
    add(0, 0, 1, 1,  1, 32'h0,  0, 32'h0);
    add(0, 0, 1, 1,  1, 32'h4,  1, 32'h0);
    add(0, 0, 1, 1,  1, 32'h8,  1, 32'h4);
    add(0, 0, 1, 1,  1, 32'hC,  1, 32'h8);
    // decode stalls: queue fills to DEPTH, requests stop
    add(0, 0, 1, 0,  1, 32'h10, 1, 32'hC);
    add(0, 0, 1, 0,  1, 32'h14, 1, 32'hC);
    add(0, 0, 1, 0,  1, 32'h18, 1, 32'hC);
    add(0, 0, 1, 0,  0, 32'h0,  1, 32'hC);
    add(0, 0, 1, 0,  0, 32'h0,  1, 32'hC);
    // drain in order, fetch resumes at 0x1C
    add(0, 0, 1, 1,  0, 32'h0,  1, 32'hC);
    add(0, 0, 1, 1,  0, 32'h0,  1, 32'h10);
    add(0, 0, 1, 1,  1, 32'h1C, 1, 32'h14);
    add(0, 0, 1, 1,  1, 32'h20, 1, 32'h18);
    add(0, 0, 1, 1,  1, 32'h24, 1, 32'h1C);
    // ack delayed 3 cycles: address held
    add(0, 0, 0, 1,  1, 32'h28, 1, 32'h20);
    add(0, 0, 0, 1,  1, 32'h28, 1, 32'h24);
    add(0, 0, 0, 1,  1, 32'h28, 0, 32'h0);
    add(0, 0, 1, 1,  1, 32'h28, 0, 32'h0);
    add(0, 0, 0, 1,  1, 32'h2C, 1, 32'h28);
    // redirect while outstanding: old response dropped
    add(1, 32'h103, 0, 1,  1, 32'h2C,  0, 32'h0);
    add(0, 0, 0, 1,  1, 32'h2C,  0, 32'h0);
    add(0, 0, 1, 1,  1, 32'h2C,  0, 32'h0);
    add(0, 0, 1, 1,  0, 32'h0,   0, 32'h0);
    add(0, 0, 0, 1,  1, 32'h100, 0, 32'h0);
    add(0, 0, 1, 1,  1, 32'h100, 0, 32'h0);
    add(0, 0, 1, 1,  1, 32'h104, 1, 32'h100);
    // redirect with push and pop in the same cycle, 2 queued
    add(0, 0, 1, 0,  1, 32'h108, 1, 32'h104);
    add(1, 32'h200, 1, 1,  1, 32'h10C, 1, 32'h104);
    add(0, 0, 1, 1,  0, 32'h0,   0, 32'h0);
    add(0, 0, 1, 1,  1, 32'h200, 0, 32'h0);
    add(0, 0, 1, 1,  1, 32'h204, 1, 32'h200);
    // address wrap from 0xFFFF_FFFC
    add(1, 32'hFFFF_FFFE, 0, 1,  1, 32'h208, 1, 32'h204);
    add(0, 0, 1, 1,  1, 32'h208,       0, 32'h0);
    add(0, 0, 1, 1,  0, 32'h0,         0, 32'h0);
    add(0, 0, 1, 1,  1, 32'hFFFF_FFFC, 0, 32'h0);
    add(0, 0, 1, 1,  1, 32'h0,         1, 32'hFFFF_FFFC);
    add(0, 0, 0, 1,  1, 32'h4,         1, 32'h0);
    add(0, 0, 0, 1,  1, 32'h4,         0, 32'h0);

    #1;
    chk_out("reset", 0, 32'h0, 0, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < tv.size(); i++) begin
      redirect    = tv[i].redir;
      redirect_pc = tv[i].rpc;
      imem_ack    = tv[i].ack;
      instr_ready = tv[i].rdy;
      #1;
      chk_out($sformatf("v%0d", i), tv[i].req, tv[i].addr,
              tv[i].vld, tv[i].pc);
      @(negedge clk);
    end
    redirect = 1'b0;
    imem_ack = 1'b0;

    // asynchronous reset while a request is outstanding
    #1;
    chk("pre_areset req", 32'(imem_req), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk_out("areset", 0, 32'h0, 0, 32'h0);

    @(negedge clk);
    reset       = 1'b1;
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    #1;
    chk_out("rst_r0", 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    #1;
    chk_out("rst_r1", 1, 32'h0, 0, 32'h0);
    @(negedge clk);
    #1;
    chk_out("rst_r2", 1, 32'h4, 1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
